cr_kme_fifo_unpacker: RTL and testbench

- Reader at the output end of a KME stall/ack FIFO.
- Pops one wide entry per handshake (`fifo_out_valid` / `fifo_out_ack`) and serialises it LSB-first into narrow beats for a downstream valid/stall consumer.
- A per-entry beat count allows short entries, and a last flag marks the final beat of a frame.
- Zero-bubble: the next entry is popped in the same cycle the final beat of the current entry is taken.

---
 rtl/cr_kme_unpack_pkg.sv | 24 ++
 rtl/cr_kme_fifo_unpacker.sv | 92 +++++++++
 tb/tb_cr_kme_fifo_unpacker.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/cr_kme_unpack_pkg.sv
// Shared types and helpers for the KME FIFO unpacker: FSM state encoding,
// default geometry and the effective beat-count rule.
package cr_kme_unpack_pkg;

    localparam int unsigned IN_WIDTH_DEF  = 256;
    localparam int unsigned OUT_WIDTH_DEF = 64;
    localparam int unsigned BEATS         = IN_WIDTH_DEF / OUT_WIDTH_DEF;
    localparam int unsigned CW            = $clog2(BEATS + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // A count of 0 means a full entry; anything above the entry size is clamped.
    function automatic int unsigned eff_beats(input int unsigned raw,
                                              input int unsigned max_beats);
        int unsigned r;
        if (raw == 0 || raw > max_beats) r = max_beats;
        else                             r = raw;
        return r;
    endfunction

endpackage

// File: rtl/cr_kme_fifo_unpacker.sv
// Pops wide entries from a stall/ack FIFO and serialises them LSB-first into
// narrow valid/stall beats, with zero-bubble refill on the final beat.
module cr_kme_fifo_unpacker
    import cr_kme_unpack_pkg::*;
#(
    parameter  int unsigned IN_WIDTH  = IN_WIDTH_DEF,
    parameter  int unsigned OUT_WIDTH = OUT_WIDTH_DEF,
    localparam int unsigned BEATS_P   = IN_WIDTH / OUT_WIDTH,
    localparam int unsigned CW_P      = $clog2(BEATS_P + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  fifo_out,
    input  logic                 fifo_out_valid,
    output logic                 fifo_out_ack,
    input  logic [CW_P-1:0]      fifo_out_beats,
    input  logic                 fifo_out_last,
    output logic [OUT_WIDTH-1:0] beat_out,
    output logic                 beat_valid,
    input  logic                 beat_stall,
    output logic                 beat_last,
    output logic                 protocol_error,
    output state_e               dbg_state
);

    localparam int unsigned IW = (BEATS_P > 1) ? $clog2(BEATS_P) : 1;

    state_e                             state_q, state_d;
    logic [BEATS_P-1:0][OUT_WIDTH-1:0]  hold_q, hold_d;
    logic [CW_P-1:0]                    idx_q, idx_d;
    logic [CW_P-1:0]                    cnt_q, cnt_d;
    logic                               lastf_q, lastf_d;
    logic                               perr_q, perr_d;

    logic take;
    logic fin;

    // Handshakes: upstream pops when fifo_out_valid & fifo_out_ack in the same
    // cycle; downstream takes a beat when beat_valid & ~beat_stall, and beat
    // data/last stay stable while stalled.
    assign beat_valid   = (state_q == SHIFT);
    assign take         = beat_valid & ~beat_stall;
    assign fin          = (idx_q == (cnt_q - CW_P'(1)));
    assign fifo_out_ack = ~rst & fifo_out_valid & ((state_q == IDLE) | (take & fin));

    assign beat_out       = hold_q[idx_q[IW-1:0]];
    assign beat_last      = beat_valid & lastf_q & fin;
    assign protocol_error = perr_q;
    assign dbg_state      = state_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        lastf_d = lastf_q;
        perr_d  = 1'b0;
        if (fifo_out_ack) begin
            hold_d  = fifo_out;
            idx_d   = '0;
            lastf_d = fifo_out_last;
            state_d = SHIFT;
            cnt_d   = CW_P'(eff_beats(32'(fifo_out_beats), BEATS_P));
            perr_d  = (32'(fifo_out_beats) > BEATS_P);
        end else if (take) begin
            // A final take without an ack means the FIFO was empty.
            if (fin) state_d = IDLE;
            else     idx_d   = idx_q + CW_P'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            lastf_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            lastf_q <= lastf_d;
            perr_q  <= perr_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

endmodule

// File: tb/tb_cr_kme_fifo_unpacker.sv
// Bench for cr_kme_fifo_unpacker: FIFO and expected-beat queues model the
// stream; directed scenarios followed by randomized traffic.
module tb_cr_kme_fifo_unpacker;
    import cr_kme_unpack_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic [255:0]  fifo_out = '0;
    logic          fifo_out_valid = 1'b0;
    logic          fifo_out_ack;
    logic [2:0]    fifo_out_beats = '0;
    logic          fifo_out_last = 1'b0;
    logic [63:0]   beat_out;
    logic          beat_valid;
    logic          beat_stall = 1'b0;
    logic          beat_last;
    logic          protocol_error;
    state_e        dbg_state;

    cr_kme_fifo_unpacker dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_out       (fifo_out),
        .fifo_out_valid (fifo_out_valid),
        .fifo_out_ack   (fifo_out_ack),
        .fifo_out_beats (fifo_out_beats),
        .fifo_out_last  (fifo_out_last),
        .beat_out       (beat_out),
        .beat_valid     (beat_valid),
        .beat_stall     (beat_stall),
        .beat_last      (beat_last),
        .protocol_error (protocol_error),
        .dbg_state      (dbg_state)
    );

    typedef struct {
        logic [255:0] data;
        int           beats;
        bit           last;
    } entry_t;

    entry_t      fifo_q[$];
    logic [64:0] exp_q[$];   // {last, data} for every beat still owed downstream
    bit          perr_exp = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic push_entry(input logic [255:0] d, input int b, input bit l);
        entry_t e;
        e.data = d; e.beats = b; e.last = l;
        fifo_q.push_back(e);
    endtask

    // One clock: drive at posedge+1, check and advance the model at negedge.
    task automatic cycle(input bit stall, input bit r);
        entry_t e;
        bit     exp_valid;
        bit     exp_ack;
        int     n;
        rst        = r;
        beat_stall = stall;
        if (fifo_q.size() > 0) begin
            fifo_out       = fifo_q[0].data;
            fifo_out_beats = 3'(fifo_q[0].beats);
            fifo_out_last  = fifo_q[0].last;
            fifo_out_valid = 1'b1;
        end else begin
            fifo_out       = rand256();
            fifo_out_beats = 3'($urandom_range(0, 7));
            fifo_out_last  = 1'($urandom_range(0, 1));
            fifo_out_valid = 1'b0;
        end
        @(negedge clk);
        if (r) begin
            check("ack_in_reset", {64'd0, fifo_out_ack}, 65'd0);
            exp_q.delete();
            perr_exp = 1'b0;
        end else begin
            exp_valid = (exp_q.size() > 0);
            exp_ack   = (fifo_q.size() > 0) && (!exp_valid || (exp_q.size() == 1 && !stall));
            check("beat_valid", {64'd0, beat_valid}, {64'd0, exp_valid});
            if (exp_valid) begin
                check("beat_out", {1'b0, beat_out}, {1'b0, exp_q[0][63:0]});
                check("beat_last", {64'd0, beat_last}, {64'd0, exp_q[0][64]});
            end else begin
                check("beat_last_idle", {64'd0, beat_last}, 65'd0);
            end
            check("fifo_out_ack", {64'd0, fifo_out_ack}, {64'd0, exp_ack});
            check("protocol_error", {64'd0, protocol_error}, {64'd0, perr_exp});
            if (exp_valid && !stall) void'(exp_q.pop_front());
            perr_exp = 1'b0;
            if (exp_ack) begin
                e = fifo_q.pop_front();
                n = (e.beats == 0 || e.beats > 4) ? 4 : e.beats;
                for (int i = 0; i < n; i++)
                    exp_q.push_back({e.last && (i == n - 1), e.data[i*64 +: 64]});
                perr_exp = (e.beats > 4);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        while ((fifo_q.size() > 0 || exp_q.size() > 0 || perr_exp) && k < 60) begin
            cycle(1'b0, 1'b0);
            k++;
        end
        check("drain_empty", 65'(fifo_q.size() + exp_q.size()), 65'd0);
    endtask

    initial begin
        logic [255:0] full_pat;
        full_pat = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        @(posedge clk);
        #1;
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);

        // single full entry, count 0 = four beats
        push_entry(full_pat, 0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0);

        // back-to-back entries with FIFO always valid
        push_entry(rand256(), 4, 1'b0);
        push_entry(rand256(), 2, 1'b1);
        drain();

        // stall on beat 2 for 3 cycles, then stall the final beat with FIFO non-empty
        push_entry(full_pat, 0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        push_entry(rand256(), 3, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
        drain();

        // one-beat entries: an ack every cycle
        for (int i = 0; i < 5; i++) push_entry(rand256(), 1, 1'(i == 4));
        drain();

        // illegal counts are clamped and flagged
        push_entry(rand256(), 7, 1'b1);
        push_entry(rand256(), 5, 1'b0);
        drain();

        // reset during beat 1 discards the partial entry
        push_entry(rand256(), 0, 1'b1);
        push_entry(rand256(), 2, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        drain();

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) != 0 && fifo_q.size() < 4)
                push_entry(rand256(), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 149) == 0));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
